png_dual_oneshot: RTL
=====================

Name: png_dual_oneshot

Overview:
- Dual retriggerable monostable, the cycle-counted equivalent of the TTL 9602 used in the Pong timing and paddle chains.
- Converts trigger edges into level pulses of programmable length. It is the pulse-generating counterpart to the edge-capturing flip-flops in the same netlist.
- Each channel has a runtime duration input, so paddle pots and ball-timing logic can drive pulse width directly.
- Sits in the video-timing and paddle sections, fully synchronous to the master clock.

Parameters:
- WIDTH, 16, bit width of each duration input and internal down-counter.

Ports:
- clk  in  1  master clock; all state updates on posedge.
- _clr  in  1  global reset, asynchronous, active-low.
- a0  in  1  channel 0 trigger A, active on falling edge.
- b0  in  1  channel 0 trigger B, active on rising edge.
- _cd0  in  1  channel 0 clear, synchronous, active-low.
- dur0  in  WIDTH  channel 0 pulse length in clk cycles, sampled at trigger.
- q0  out  1  channel 0 pulse output.
- _q0  out  1  complement of q0.
- end0  out  1  channel 0 one-cycle strobe on natural pulse expiry.
- a1, b1, _cd1, dur1, q1, _q1, end1: identical set for channel 1.

Behaviour:
- Reset (_clr=0, asynchronous):
  - counters = 0; q = 0; _q = 1; end = 0.
  - Edge-history registers: a_prev = 0, b_prev = 1. With these values no edge can be detected in the first cycle after reset release.
- Edge detection, per channel, registered history:
  - trig = (a_prev & ~a & b) | (~b_prev & b & ~a).
  - a_prev and b_prev update every cycle, including while _cd = 0.
  - The inputs are already synchronous to clk; the block adds no synchroniser.
- Counter:
  - If _cd = 0: cnt <= 0.
  - Else if trig and dur != 0: cnt <= dur.
  - Else if cnt != 0: cnt <= cnt - 1.
- Output: q = (cnt != 0), taken from registered state; _q = ~q.
  - A trigger detected in cycle t gives q high in cycles t+1 through t+dur inclusive, i.e. exactly dur cycles.
- Retrigger: a trig while q = 1 reloads cnt with the current dur. The pulse then ends dur cycles after the retrigger cycle, with no glitch low in between.
- dur = 0: the trigger is ignored; a running pulse is neither extended nor cut.
- dur is sampled only in the trigger cycle. Changing dur mid-pulse has no effect until the next trigger.
- Clear:
  - _cd = 0 forces cnt to 0 on the next edge, so q falls one cycle later.
  - Clear beats a simultaneous trigger.
  - end is not asserted for a cleared pulse.
- end strobe: registered. Asserted for exactly one cycle in the cycle after cnt goes 1 -> 0 by decrement (cycle t+dur+1). Not asserted when a retrigger reloads the counter instead.
- Channels are fully independent; simultaneous events on both channels behave per channel.
- Reset mid-pulse: q drops immediately (asynchronously) and no end strobe follows.

Decomposition:
- Shared package png_pkg gets:
  - localparams for the edge-history reset values (A_PREV_RST = 0, B_PREV_RST = 1);
  - the default duration width constant, reused by the paddle logic.
- Sub-module png_oneshot_ch holds one channel: edge detector, counter, q/_q, end. It is instantiated twice in png_dual_oneshot. The top level is wiring only.

Test Plan:
- Reset release with a0=1, b0=0, dur0=5, no further edges -> q0=0, _q0=1, end0=0 for 20 cycles.
- b0 0->1 in cycle 10 with a0=0, dur0=5 -> q0 high in cycles 11–15, end0 high in cycle 16 only.
- Same trigger, then a0 1->0 with b0=1 in cycle 13 (retrigger) -> q0 stays high continuously in cycles 11–18; a single end0 in cycle 19.
- Pulse running with dur0=100, _cd0 low in cycle 20 -> q0 low from cycle 21; no end0; a trigger in the same cycle as _cd0=0 produces no pulse.
- dur1=0, then trigger on b1 -> q1 stays low. Then dur1=3 and trigger -> exactly 3-cycle pulse while channel 0 runs an unrelated 7-cycle pulse unaffected.
- _clr asserted mid-pulse on both channels -> q0=q1=0 immediately; after release, no spurious pulse or end strobe.

Source files
------------

// File: rtl/png_pkg.sv
// Shared constants for the Pong timing/paddle netlist slice.
package png_pkg;

  // Default width of duration inputs and pulse down-counters; the paddle
  // logic sizes its pot-derived durations with the same constant.
  localparam int DUR_WIDTH = 16;

  // Edge-history reset values. With a_prev = 0 no falling edge on A can be
  // seen, and with b_prev = 1 no rising edge on B can be seen, so the first
  // cycle after reset release never fires a trigger.
  localparam logic A_PREV_RST = 1'b0;
  localparam logic B_PREV_RST = 1'b1;

endpackage

// File: rtl/png_oneshot_ch.sv
// One retriggerable monostable channel (cycle-counted 9602 half):
// edge detector on A (falling) / B (rising), programmable down-counter,
// complementary level outputs and a one-cycle natural-expiry strobe.
module png_oneshot_ch
  import png_pkg::*;
#(
  parameter int WIDTH = DUR_WIDTH
) (
  input  logic             clk,
  input  logic             i_clr_n,
  input  logic             i_a,
  input  logic             i_b,
  input  logic             i_cd_n,
  input  logic [WIDTH-1:0] i_dur,
  output logic             o_q,
  output logic             o_q_n,
  output logic             o_end
);

  logic             r_a_prev;
  logic             r_b_prev;
  logic [WIDTH-1:0] r_cnt;
  logic             r_end;

  logic             w_trig;
  logic             w_load;
  logic             w_expire;
  logic [WIDTH-1:0] w_cnt_next;

  // Falling A while B is high, or rising B while A is low.
  assign w_trig = (r_a_prev & ~i_a & i_b) | (~r_b_prev & i_b & ~i_a);

  // A zero duration makes the trigger a no-op: it neither starts nor
  // extends nor cuts a pulse.
  assign w_load = w_trig & (i_dur != '0);

  // Natural expiry only: the counter steps 1 -> 0 by decrement. A clear or
  // a reload in the same cycle suppresses the strobe.
  assign w_expire = i_cd_n & ~w_load & (r_cnt == WIDTH'(1));

  // Next counter value: clear has priority, then reload, then count down.
  always_comb begin
    w_cnt_next = r_cnt;
    if (!i_cd_n) begin
      w_cnt_next = '0;
    end else if (w_load) begin
      w_cnt_next = i_dur;
    end else if (r_cnt != '0) begin
      w_cnt_next = r_cnt - WIDTH'(1);
    end
  end

  // Edge history tracks the inputs every cycle, even while cleared.
  always_ff @(posedge clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_a_prev <= A_PREV_RST;
      r_b_prev <= B_PREV_RST;
    end else begin
      r_a_prev <= i_a;
      r_b_prev <= i_b;
    end
  end

  // Pulse counter and registered expiry strobe.
  always_ff @(posedge clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_cnt <= '0;
      r_end <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_end <= w_expire;
    end
  end

  // Outputs decode registered state only, so they are glitch-free and drop
  // immediately when the asynchronous reset clears the counter.
  assign o_q   = (r_cnt != '0);
  assign o_q_n = ~o_q;
  assign o_end = r_end;

endmodule

// File: rtl/png_dual_oneshot.sv
// Dual retriggerable monostable: two independent png_oneshot_ch channels.
// Wiring only; all behaviour lives in the channel module.
module png_dual_oneshot
  import png_pkg::*;
#(
  parameter int WIDTH = DUR_WIDTH
) (
  input  logic             clk,
  input  logic             _clr,
  input  logic             a0,
  input  logic             b0,
  input  logic             _cd0,
  input  logic [WIDTH-1:0] dur0,
  output logic             q0,
  output logic             _q0,
  output logic             end0,
  input  logic             a1,
  input  logic             b1,
  input  logic             _cd1,
  input  logic [WIDTH-1:0] dur1,
  output logic             q1,
  output logic             _q1,
  output logic             end1
);

  localparam int NCH = 2;

  logic [NCH-1:0]   w_a;
  logic [NCH-1:0]   w_b;
  logic [NCH-1:0]   w_cd_n;
  logic [NCH-1:0]   w_q;
  logic [NCH-1:0]   w_q_n;
  logic [NCH-1:0]   w_end;
  logic [WIDTH-1:0] w_dur [NCH];

  assign w_a    = {a1, a0};
  assign w_b    = {b1, b0};
  assign w_cd_n = {_cd1, _cd0};
  assign w_dur[0] = dur0;
  assign w_dur[1] = dur1;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      png_oneshot_ch #(
        .WIDTH (WIDTH)
      ) u_ch (
        .clk     (clk),
        .i_clr_n (_clr),
        .i_a     (w_a[gi]),
        .i_b     (w_b[gi]),
        .i_cd_n  (w_cd_n[gi]),
        .i_dur   (w_dur[gi]),
        .o_q     (w_q[gi]),
        .o_q_n   (w_q_n[gi]),
        .o_end   (w_end[gi])
      );
    end
  endgenerate

  assign q0   = w_q[0];
  assign _q0  = w_q_n[0];
  assign end0 = w_end[0];
  assign q1   = w_q[1];
  assign _q1  = w_q_n[1];
  assign end1 = w_end[1];

endmodule
